// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Accepts a byte stream (16-bit big-endian word count, then 4*N bytes MSB first),
// writes each assembled 32-bit word to consecutive word addresses and holds the CPU
// stalled until a complete image has been written.
module imem_loader #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              cpu_hold
);

   localparam int unsigned      CNT_W      = $clog2(TIMEOUT) + 1;
   // Last idle count that still tolerates a byte; the next idle edge aborts.
   localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT - 2);
   localparam logic [32:0]      MAX_WORDS  = 33'(1) << ADDR_W;

   typedef enum logic [2:0] {
      StIdle,
      StHdrHi,
      StHdrLo,
      StData,
      StWrite,
      StDone,
      StErr
   } state_e;

   state_e            state_q, state_d;
   logic [15:0]       count_q, count_d;
   logic [ADDR_W-1:0] word_idx_q, word_idx_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [31:0]       word_q, word_d;
   logic [CNT_W-1:0]  idle_q, idle_d;

   logic              accept;
   logic [15:0]       hdr_n;
   logic              last_word;

   // Outputs are pure decodes of state and registers; no path from in_valid.
   assign in_ready = (state_q == StHdrHi) || (state_q == StHdrLo) || (state_q == StData);
   assign we       = (state_q == StWrite);
   assign waddr    = word_idx_q;
   assign wdata    = word_q;
   assign busy     = in_ready || we;
   assign done     = (state_q == StDone);
   assign error    = (state_q == StErr);
   assign cpu_hold = (state_q != StDone);

   assign accept    = in_valid && in_ready;
   assign hdr_n     = {count_q[15:8], in_data};
   assign last_word = ((33'(word_idx_q) + 33'd1) == 33'(count_q));

   // Next-state logic: header decode, byte assembly, write sequencing, idle timeout.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      idle_d     = idle_q;

      unique case (state_q)
         StIdle: begin
            if (start) state_d = StHdrHi;
         end
         StHdrHi: begin
            // No timeout while waiting for the first header byte.
            idle_d = '0;
            if (accept) begin
               count_d[15:8] = in_data;
               state_d       = StHdrLo;
            end
         end
         StHdrLo: begin
            if (accept) begin
               count_d[7:0] = in_data;
               idle_d       = '0;
               if (hdr_n == 16'd0) begin
                  state_d = StDone;
               end else if (33'(hdr_n) > MAX_WORDS) begin
                  state_d = StErr;
               end else begin
                  state_d    = StData;
                  word_idx_d = '0;
                  byte_idx_d = '0;
               end
            end else if (idle_q == IDLE_LIMIT) begin
               state_d = StErr;
            end else begin
               idle_d = idle_q + CNT_W'(1);
            end
         end
         StData: begin
            if (accept) begin
               word_d     = {word_q[23:0], in_data};
               idle_d     = '0;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) state_d = StWrite;
            end else if (idle_q == IDLE_LIMIT) begin
               state_d = StErr;
            end else begin
               idle_d = idle_q + CNT_W'(1);
            end
         end
         StWrite: begin
            idle_d = '0;
            if (last_word) begin
               state_d = StDone;
            end else begin
               word_idx_d = word_idx_q + ADDR_W'(1);
               state_d    = StData;
            end
         end
         StDone, StErr: begin
            idle_d = '0;
            if (start) state_d = StHdrHi;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset aborts any load, dropping an in-flight write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         count_q    <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
         idle_q     <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         idle_q     <= idle_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized frames checked against a frame-level
// reference model (expected write list computed straight from the byte stream).
module tb_imem_loader;

   localparam int unsigned ADDR_W  = 10;
   localparam int unsigned TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;
   logic              busy;
   logic              done;
   logic              error;
   logic              cpu_hold;

   imem_loader #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .cpu_hold (cpu_hold)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int last_iters;
   int rdy_bad  = 0;

   logic [7:0]  frame[$];
   logic [41:0] exp_q[$];
   logic [41:0] obs_q[$];
   logic        exp_done;
   logic        exp_err;

   // Record every write strobe seen by the instruction RAM.
   always @(negedge clk) begin
      if (we) begin
         obs_q.push_back({waddr, wdata});
         if (in_ready) rdy_bad++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: the frame's words at consecutive addresses, or a terminal status.
   function automatic void model();
      int n;
      exp_q.delete();
      n        = {frame[0], frame[1]};
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (n == 0) begin
         exp_done = 1'b1;
      end else if (n > (1 << ADDR_W)) begin
         exp_err = 1'b1;
      end else begin
         for (int w = 0; w < n; w++) begin
            exp_q.push_back({10'(w), frame[2+4*w], frame[3+4*w], frame[4+4*w], frame[5+4*w]});
         end
         exp_done = 1'b1;
      end
   endfunction

   task automatic make_frame(input int n);
      frame.delete();
      frame.push_back(8'(n >> 8));
      frame.push_back(8'(n));
      for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
   endtask

   task automatic step(input int k);
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   // mode 0: valid always high, 1: toggling, 2: random. start pulsed on iteration start_at.
   task automatic send(input int mode, input int start_at);
      int   idx;
      int   it;
      logic acc;
      idx = 0;
      it  = 0;
      while (idx < frame.size() && it < 20 * frame.size() + 100) begin
         in_data = frame[idx];
         case (mode)
            0:       in_valid = 1'b1;
            1:       in_valid = (it % 2 == 0);
            default: in_valid = ($urandom_range(0, 3) != 0);
         endcase
         start = (it == start_at);
         acc   = in_valid && in_ready;
         step(1);
         if (acc) idx++;
         it++;
      end
      in_valid   = 1'b0;
      start      = 1'b0;
      last_iters = it;
      check("send_complete", 64'(idx), 64'(frame.size()));
   endtask

   task automatic finish_check(input string tag);
      int mism;
      for (int i = 0; i < 20 && !(done || error); i++) step(1);
      check({tag, "_done"}, done, exp_done);
      check({tag, "_error"}, error, exp_err);
      check({tag, "_cpu_hold"}, cpu_hold, !exp_done);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_wr_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      mism = 0;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) mism++;
      check({tag, "_wr_mismatches"}, 64'(mism), 64'd0);
      check({tag, "_rdy_during_we"}, 64'(rdy_bad), 64'd0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_in_ready"}, in_ready, 1'b0);
      check({tag, "_we"}, we, 1'b0);
      check({tag, "_waddr"}, 64'(waddr), 64'd0);
      check({tag, "_wdata"}, 64'(wdata), 64'd0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_error"}, error, 1'b0);
      check({tag, "_cpu_hold"}, cpu_hold, 1'b1);
   endtask

   task automatic new_frame();
      obs_q.delete();
      rdy_bad = 0;
   endtask

   initial begin
      int early;
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      step(2);
      check_reset("reset");
      rst = 1'b0;

      // IDLE ignores the stream.
      in_valid = 1'b1;
      step(3);
      in_valid = 1'b0;
      check("idle_in_ready", in_ready, 1'b0);
      check("idle_no_we", 64'(obs_q.size()), 64'd0);

      // Basic image, valid always high: exact write timing and throughput.
      new_frame();
      frame = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
      model();
      pulse_start();
      check("busy_hdr", busy, 1'b1);
      send(0, -1);
      check("basic_iters", 64'(last_iters), 64'd11);
      check("basic_we_latency", we, 1'b1);
      check("basic_waddr", 64'(waddr), 64'd1);
      check("basic_wdata", 64'(wdata), 64'h00000008);
      check("basic_hold_in_write", cpu_hold, 1'b1);
      step(1);
      check("basic_done_next", done, 1'b1);
      check("basic_hold_fall", cpu_hold, 1'b0);
      check("basic_we_single", we, 1'b0);
      finish_check("basic");

      // Same image, in_valid toggling.
      new_frame();
      pulse_start();
      send(1, -1);
      finish_check("toggle");

      // Empty image.
      new_frame();
      frame = '{8'h00, 8'h00};
      model();
      pulse_start();
      send(0, -1);
      check("empty_done_next", done, 1'b1);
      finish_check("empty");

      // Oversized image (N = 1025).
      new_frame();
      frame = '{8'h04, 8'h01};
      model();
      pulse_start();
      send(0, -1);
      finish_check("oversize");

      // Timeout: header 00 01, two bytes, then silence.
      new_frame();
      frame = '{8'h00, 8'h01, 8'hAA, 8'hBB};
      pulse_start();
      send(0, -1);
      early = 0;
      for (int k = 1; k < 15; k++) begin
         step(1);
         if (error) early++;
      end
      check("timeout_not_early", 64'(early), 64'd0);
      step(1);
      check("timeout_error", error, 1'b1);
      check("timeout_hold", cpu_hold, 1'b1);
      check("timeout_no_we", 64'(obs_q.size()), 64'd0);

      // Restart from ERR; a byte on the last tolerated idle cycle is still accepted.
      new_frame();
      frame = '{8'h00, 8'h01, 8'h11};
      pulse_start();
      check("err_cleared", error, 1'b0);
      send(0, -1);
      step(14);
      check("boundary_no_error", error, 1'b0);
      frame = '{8'h22, 8'h33, 8'h44};
      send(0, -1);
      frame = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
      model();
      finish_check("boundary");

      // Reset after three data bytes of word 0.
      new_frame();
      frame = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
      pulse_start();
      send(0, -1);
      rst = 1'b1;
      #1;
      check_reset("midload_rst");
      step(2);
      rst = 1'b0;
      check("midload_no_we", 64'(obs_q.size()), 64'd0);
      new_frame();
      make_frame(2);
      model();
      pulse_start();
      send(2, -1);
      finish_check("after_rst");

      // Reset during the WRITE cycle drops the write at once.
      new_frame();
      frame = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      pulse_start();
      send(0, -1);
      check("wr_rst_we_before", we, 1'b1);
      rst = 1'b1;
      #1;
      check_reset("wr_rst");
      step(2);
      rst = 1'b0;
      check("wr_rst_no_we", 64'(obs_q.size()), 64'd0);

      // start during DATA is ignored.
      new_frame();
      make_frame(2);
      model();
      pulse_start();
      send(0, 4);
      finish_check("start_in_data");

      // Random small images with random valid gaps.
      for (int r = 0; r < 4; r++) begin
         new_frame();
         make_frame($urandom_range(1, 6));
         model();
         pulse_start();
         send(2, -1);
         finish_check("random");
      end

      // Full memory: N = 2^ADDR_W.
      new_frame();
      make_frame(1 << ADDR_W);
      model();
      pulse_start();
      send(2, -1);
      finish_check("full");
      check("full_last_addr", 64'(obs_q[obs_q.size()-1][41:32]), 64'd1023);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory that the fetch stage reads through a word address. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and drives the instruction RAM write port at consecutive word addresses. It holds the CPU stalled until a complete image has been written.

## Interface

Parameters
- ADDR_W, 10, word-address width of instruction memory (byte address bits [ADDR_W+1:2])
- TIMEOUT, 1000000, maximum idle cycles between bytes once a load has started

Ports
- clk  in  1  system clock, all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a new load
- in_data  in  8  stream byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader can accept a byte this cycle
- we  out  1  instruction RAM write strobe, one cycle per word
- waddr  out  ADDR_W  instruction RAM word address
- wdata  out  32  instruction word
- busy  out  1  load in progress
- done  out  1  image fully written, level
- error  out  1  load aborted, level
- cpu_hold  out  1  stall/hold request to the CPU, low only when done

## Operation

- A byte is accepted on a posedge where in_valid && in_ready.
- Frame format:
  - 16-bit word count N, high byte first.
  - Then 4*N bytes, each word MSB first: the first byte lands in wdata[31:24].
- States:
  - IDLE: in_ready=0. start moves to HDR_HI.
  - HDR_HI: in_ready=1. Accepting a byte stores N[15:8] and moves to HDR_LO. No timeout applies in this state.
  - HDR_LO: in_ready=1. Accepting a byte stores N[7:0], then:
    - N==0: go to DONE.
    - N > 2^ADDR_W: go to ERR.
    - Otherwise: go to DATA with the word index and byte index cleared.
  - DATA: in_ready=1. Each accepted byte shifts into the word register. On the 4th byte of a word, go to WRITE.
  - WRITE: in_ready=0, we=1 for exactly one cycle with waddr = word index and wdata = assembled word. Then:
    - Word index+1 == N: go to DONE.
    - Otherwise: increment word index and return to DATA.
  - DONE: done=1, cpu_hold=0. start moves to HDR_HI and clears done.
  - ERR: error=1, cpu_hold=1. start moves to HDR_HI and clears error.
- start is ignored in HDR_HI, HDR_LO, DATA and WRITE.
- Timeout:
  - An idle counter clears on every accepted byte and on entry to HDR_LO or DATA.
  - It increments each cycle in HDR_LO or DATA without an accepted byte.
  - Reaching TIMEOUT-1 moves the block to ERR. Words already written stay written; no rollback.
- busy=1 in HDR_HI, HDR_LO, DATA and WRITE.
- Bytes beyond 4*N are not accepted (in_ready=0 in DONE).
- N == 2^ADDR_W is legal and fills memory exactly. waddr never wraps.

## Timing

- Reset values: state IDLE, in_ready 0, we 0, waddr 0, wdata 0, busy 0, done 0, error 0, cpu_hold 1. All counters are 0.
- Reset asserted mid-load aborts immediately. An in-flight write is dropped: we deasserts asynchronously.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid to in_ready.
- Write latency: we asserts the cycle after the posedge that accepted the 4th byte of a word.
- Peak throughput: 4 bytes per 5 cycles.
- done rises the cycle after the last WRITE, or the cycle after HDR_LO when N==0. cpu_hold falls in the same cycle.
- Timeout boundary: with TIMEOUT=T, a byte arriving on the (T-1)th idle cycle is still accepted. Missing that cycle gives ERR on the next edge.

## Test plan

- Reset then start, stream 00 02 | 24 08 00 05 | 00 00 00 08 with in_valid always high:
  - we pulses twice: (waddr 0, 0x24080005) and (waddr 1, 0x00000008).
  - done=1 and cpu_hold=0 one cycle after the second write.
- Same image with in_valid toggling every other cycle: identical writes, no byte lost or duplicated, in_ready=0 on both WRITE cycles.
- Header 00 00: done=1 with no we pulse. Header 04 01 with ADDR_W=10 (N=1025): error=1, no we, cpu_hold=1.
- TIMEOUT=16, header 00 01 then 2 bytes then silence: error=1 exactly 15 idle cycles after the 2nd byte. A subsequent start followed by a valid frame ends in done.
- rst pulsed after 3 data bytes of word 0: all outputs return to reset values, no we pulse. After start, a new frame loads from waddr 0.
- start pulsed during DATA: ignored. The load completes normally.
